bcd_play_timer: RTL

- Parametrised BCD mm:ss play-time counter for the music-player display path.
- Counts up (elapsed time) or down (remaining time, from a loaded preset) on a one-cycle tick enable, not on the raw clock.
- Has run/pause/clear control, lap freeze of the displayed value, and a terminal-count flag.
- Feeds the SSD scan/mux block.
- Mode decoding stays in the top-level FSM, which drives start/pause/clear.

---
 rtl/bcd_play_timer_if.sv | 35 +++
 rtl/bcd_play_timer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bcd_play_timer_if.sv
// Control and display bundle of the BCD mm:ss play timer.
// The master drives the controls; the timer (slave) drives the display digits and flags.
interface bcd_play_timer_if #(
  parameter int MIN_DIGITS = 2
) ();
  logic                    tick;
  logic                    start;
  logic                    pause;
  logic                    clear;
  logic                    dir;
  logic                    load;
  logic [4*MIN_DIGITS-1:0] load_min;
  logic [7:0]              load_sec;
  logic                    lap;
  logic [3:0]              sec_ones;
  logic [3:0]              sec_tens;
  logic [4*MIN_DIGITS-1:0] min_bcd;
  logic                    running;
  logic                    done;
  logic                    ovf;

  modport master (
    output tick, start, pause, clear, dir, load,
    output load_min, load_sec, lap,
    input  sec_ones, sec_tens, min_bcd,
    input  running, done, ovf
  );

  modport slave (
    input  tick, start, pause, clear, dir, load,
    input  load_min, load_sec, lap,
    output sec_ones, sec_tens, min_bcd,
    output running, done, ovf
  );
endinterface

// File: rtl/bcd_play_timer.sv
// BCD mm:ss play timer: up/down count on tick, run/pause/clear,
// lap freeze of the display and a terminal-count flag.
module bcd_play_timer #(
  parameter int MIN_DIGITS = 2,
  parameter bit WRAP       = 1'b0
) (
  input logic             clk,
  input logic             rst,
  bcd_play_timer_if.slave bus
);

  localparam int W  = 4*MIN_DIGITS + 8;
  localparam int ND = MIN_DIGITS + 2;
  localparam logic [W-1:0] MAXV = {{MIN_DIGITS{4'h9}}, 8'h59};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Digit 1 is seconds tens (0..5); every other digit is 0..9.
  function automatic logic [3:0] lim(input int i);
    return (i == 1) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [3:0] sat(input logic [3:0] d,
                                     input logic [3:0] m);
    return (d > m) ? m : d;
  endfunction

  function automatic logic [W-1:0] inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (c) begin
        if (v[4*i +: 4] == lim(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = lim(i);
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] clamp(
    input logic [4*MIN_DIGITS-1:0] m,
    input logic [7:0]              s
  );
    logic [W-1:0] r;
    r      = '0;
    r[3:0] = sat(s[3:0], 4'd9);
    r[7:4] = sat(s[7:4], 4'd5);
    for (int i = 0; i < MIN_DIGITS; i++) begin
      r[8+4*i +: 4] = sat(m[4*i +: 4], 4'd9);
    end
    return r;
  endfunction

  logic [1:0]   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] snap_q, snap_d;
  logic [W-1:0] disp_q, disp_d;
  logic         dir_q, dir_d;
  logic         frz_q, frz_d;
  logic         run_q, done_q, done_d;
  logic         ovf_q, ovf_d;
  logic         zero, at_max, start_ok;
  logic [W-1:0] nxt_dn;

  assign zero   = (cnt_q == '0);
  assign at_max = (cnt_q == MAXV);
  assign nxt_dn = dec(cnt_q);

  // Down from zero is pointless; up from a saturated DONE is too.
  assign start_ok = bus.dir ? !zero
                  : !(!WRAP && at_max && state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    ovf_d   = 1'b0;
    frz_d   = frz_q ^ bus.lap;
    snap_d  = (bus.lap && !frz_q) ? cnt_q : snap_q;
    if (bus.clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      frz_d   = 1'b0;
    end else if (bus.load && state_q != S_RUN) begin
      cnt_d = clamp(bus.load_min, bus.load_sec);
    end else if (bus.pause) begin
      if (state_q == S_RUN) state_d = S_PAUSE;
    end else if (bus.start && state_q != S_RUN) begin
      if (start_ok) begin
        state_d = S_RUN;
        dir_d   = bus.dir;
      end
    end else if (bus.tick && state_q == S_RUN) begin
      if (!dir_q) begin
        if (!at_max) begin
          cnt_d = inc(cnt_q);
        end else if (WRAP) begin
          cnt_d = '0;
          ovf_d = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end else if (zero || nxt_dn == '0) begin
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        cnt_d = nxt_dn;
      end
    end
    disp_d = frz_d ? snap_d : cnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      disp_q  <= '0;
      dir_q   <= 1'b0;
      frz_q   <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      disp_q  <= disp_d;
      dir_q   <= dir_d;
      frz_q   <= frz_d;
      run_q   <= (state_d == S_RUN);
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.sec_ones = disp_q[3:0];
  assign bus.sec_tens = disp_q[7:4];
  assign bus.min_bcd  = disp_q[W-1:8];
  assign bus.running  = run_q;
  assign bus.done     = done_q;
  assign bus.ovf      = ovf_q;

endmodule
